// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared definitions for the ES1 SPU op chain.
// Holds the underflow counter width and its saturating increment.
package elixirchip_es1_spu_pkg;

    localparam int UNDERFLOW_CNT_BITS = 16;
    localparam logic [UNDERFLOW_CNT_BITS-1:0] UNDERFLOW_CNT_MAX = 16'hFFFF;

    function automatic logic [UNDERFLOW_CNT_BITS-1:0] sat_inc(
        input logic [UNDERFLOW_CNT_BITS-1:0] value
    );
        return (value == UNDERFLOW_CNT_MAX) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_fifo_sync.sv
// Register-based synchronous FIFO with show-ahead read data and async reset.
// Occupancy is tracked in a registered count one bit wider than the pointers.
module elixirchip_es1_spu_fifo_sync #(
    parameter int DATA_BITS = 8,
    parameter int PTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_BITS:0]    count
);

    localparam int DEPTH = 1 << PTR_BITS;
    localparam logic [PTR_BITS:0] COUNT_FULL = (PTR_BITS + 1)'(DEPTH);
    localparam logic [PTR_BITS:0] COUNT_ZERO = {(PTR_BITS + 1){1'b0}};

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]    count_q, count_d;
    logic                 wr_ok_s, rd_ok_s;

    assign full    = (count_q == COUNT_FULL);
    assign empty   = (count_q == COUNT_ZERO);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state: guarded write/read, pointer wrap by natural overflow.
    always_comb begin
        wr_ok_s  = wr_en & ~full;
        rd_ok_s  = rd_en & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + (PTR_BITS + 1)'(1);
            2'b01:   count_d = count_q - (PTR_BITS + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_q <= {PTR_BITS{1'b0}};
            rd_ptr_q <= {PTR_BITS{1'b0}};
            count_q  <= COUNT_ZERO;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_source.sv
// AXI4-Stream to SPU op-chain source: buffers beats and flags each frame start with clear.
// Optional starved-cycle counter enabled by ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN.
module elixirchip_es1_spu_op_source
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int  DATA_BITS     = 8,
    parameter type data_t        = logic [DATA_BITS-1:0],
    parameter int  FIFO_PTR_BITS = 2,
    parameter data_t CLEAR_DATA  = 'x,
    parameter      DEVICE        = "RTL",
    parameter      SIMULATION    = "false",
    parameter      DEBUG         = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  logic  enable,
    input  data_t s_axis_tdata,
    input  logic  s_axis_tlast,
    input  logic  s_axis_tvalid,
    output logic  s_axis_tready,
    output data_t m_data,
    output logic  m_clear,
    output logic  m_valid
`ifdef ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN
    ,
    output logic [UNDERFLOW_CNT_BITS-1:0] m_underflow_count
`endif
);

    typedef struct packed {
        data_t data;
        logic  last;
    } entry_t;

    localparam int ENTRY_BITS = $bits(entry_t);

    entry_t               wr_entry_s;
    entry_t               rd_entry_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic [FIFO_PTR_BITS:0] fifo_count_s;
    logic                 push_s, pop_s;
    logic                 cfg_unused_s;

    logic  ready_q, ready_d;
    data_t m_data_q, m_data_d;
    logic  m_clear_q, m_clear_d;
    logic  m_valid_q, m_valid_d;
    logic  sof_q, sof_d;

    assign wr_entry_s.data = s_axis_tdata;
    assign wr_entry_s.last = s_axis_tlast;

    // ready_q keeps tready low until the first edge after reset release.
    assign s_axis_tready = ready_q & ~fifo_full_s;
    assign push_s        = s_axis_tvalid & s_axis_tready;
    assign pop_s         = cke & enable & ~fifo_empty_s;
    assign cfg_unused_s  = ^{fifo_count_s, DEVICE, SIMULATION, DEBUG};

    elixirchip_es1_spu_fifo_sync #(
        .DATA_BITS (ENTRY_BITS),
        .PTR_BITS  (FIFO_PTR_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_s),
        .wr_data (wr_entry_s),
        .rd_en   (pop_s),
        .rd_data (rd_entry_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Output stage: only cke-qualified edges update outputs and frame-start state.
    always_comb begin
        ready_d   = 1'b1;
        m_data_d  = m_data_q;
        m_clear_d = m_clear_q;
        m_valid_d = m_valid_q;
        sof_d     = sof_q;
        if (cke) begin
            if (pop_s) begin
                m_data_d  = rd_entry_s.data;
                m_valid_d = 1'b1;
                m_clear_d = sof_q;
                sof_d     = rd_entry_s.last;
            end else begin
                m_valid_d = 1'b0;
                m_clear_d = 1'b0;
            end
        end else begin
            sof_d = sof_q;
        end
    end

    // Output and frame-state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b0;
            m_data_q  <= CLEAR_DATA;
            m_clear_q <= 1'b0;
            m_valid_q <= 1'b0;
            sof_q     <= 1'b1;
        end else begin
            ready_q   <= ready_d;
            m_data_q  <= m_data_d;
            m_clear_q <= m_clear_d;
            m_valid_q <= m_valid_d;
            sof_q     <= sof_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_clear = m_clear_q;
    assign m_valid = m_valid_q;

`ifdef ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN
    logic [UNDERFLOW_CNT_BITS-1:0] uf_cnt_q, uf_cnt_d;

    // Count starvation inside a frame; sof high means between frames, not starved.
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (cke & enable & fifo_empty_s & ~sof_q) begin
            uf_cnt_d = sat_inc(uf_cnt_q);
        end else begin
            uf_cnt_d = uf_cnt_q;
        end
    end

    // Underflow counter register; cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uf_cnt_q <= {UNDERFLOW_CNT_BITS{1'b0}};
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign m_underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_source.sv
// Directed self-checking bench for elixirchip_es1_spu_op_source (depth 4, 8-bit data).
// Underflow-counter checks are compiled in with ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN.
module tb_elixirchip_es1_spu_op_source;

    logic       clk = 1'b0;
    logic       reset;
    logic       cke;
    logic       enable;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tlast;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_data;
    logic       m_clear;
    logic       m_valid;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN
    logic [15:0] m_underflow_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_source #(
        .DATA_BITS     (8),
        .FIFO_PTR_BITS (2),
        .CLEAR_DATA    (8'h00)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cke               (cke),
        .enable            (enable),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_data            (m_data),
        .m_clear           (m_clear),
        .m_valid           (m_valid)
`ifdef ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN
        ,
        .m_underflow_count (m_underflow_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic c);
        check({tag, ".valid"}, {31'd0, m_valid}, 32'd1);
        check({tag, ".data"},  {24'd0, m_data},  {24'd0, d});
        check({tag, ".clear"}, {31'd0, m_clear}, {31'd0, c});
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {31'd0, m_valid}, 32'd0);
        check({tag, ".clear"}, {31'd0, m_clear}, 32'd0);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cke = 1'b1;
        enable = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        check("rst.tready", {31'd0, s_axis_tready}, 32'd0);
        check_idle("rst");
        check("rst.data", {24'd0, m_data}, 32'd0);
        reset = 1'b0;

        // Idle after reset: nothing output, ready, no counting while sof=1
        repeat (10) tick();
        check("idle.tready", {31'd0, s_axis_tready}, 32'd1);
        check_idle("idle");
`ifdef ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN
        check("idle.ufcnt", {16'd0, m_underflow_count}, 32'd0);
`endif

        // Frames {11,22,33} and {44}, continuous
        drive(1'b1, 8'h11, 1'b0);
        tick();
        check("f.lat", {31'd0, m_valid}, 32'd0);
        drive(1'b1, 8'h22, 1'b0);
        tick();
        check_beat("f.b11", 8'h11, 1'b1);
        drive(1'b1, 8'h33, 1'b1);
        tick();
        check_beat("f.b22", 8'h22, 1'b0);
        drive(1'b1, 8'h44, 1'b1);
        tick();
        check_beat("f.b33", 8'h33, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check_beat("f.b44", 8'h44, 1'b1);
        tick();
        check_idle("f.end");

        // Fill with enable=0: 4 accepts then backpressure
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 1'b0);
            tick();
        end
        check("full.tready", {31'd0, s_axis_tready}, 32'd0);
        check_idle("full.hold");
        drive(1'b1, 8'h54, 1'b0);
        tick();
        check("full.tready2", {31'd0, s_axis_tready}, 32'd0);
        enable = 1'b1;
        tick();
        check_beat("full.b50", 8'h50, 1'b1);
        check("full.tready3", {31'd0, s_axis_tready}, 32'd1);
        tick();
        check_beat("full.b51", 8'h51, 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        tick();
        check_beat("full.b52", 8'h52, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check_beat("full.b53", 8'h53, 1'b0);
        tick();
        check_beat("full.b54", 8'h54, 1'b0);
        tick();
        check_beat("full.b55", 8'h55, 1'b0);
        tick();
        check_idle("full.end");

        // cke toggling: outputs hold on cke=0, pushes continue
        cke = 1'b0;
        drive(1'b1, 8'h61, 1'b0);
        tick();
        drive(1'b1, 8'h62, 1'b0);
        tick();
        check_idle("cke.pre");
        drive(1'b1, 8'h63, 1'b0);
        cke = 1'b1;
        tick();
        check_beat("cke.b61", 8'h61, 1'b1);
        drive(1'b1, 8'h64, 1'b1);
        cke = 1'b0;
        tick();
        check_beat("cke.h61", 8'h61, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        cke = 1'b1;
        tick();
        check_beat("cke.b62", 8'h62, 1'b0);
        cke = 1'b0;
        tick();
        check_beat("cke.h62", 8'h62, 1'b0);
        cke = 1'b1;
        tick();
        check_beat("cke.b63", 8'h63, 1'b0);
        cke = 1'b0;
        tick();
        check_beat("cke.h63", 8'h63, 1'b0);
        cke = 1'b1;
        tick();
        check_beat("cke.b64", 8'h64, 1'b0);
        cke = 1'b0;
        tick();
        check_beat("cke.h64", 8'h64, 1'b0);
        cke = 1'b1;
        tick();
        check_idle("cke.end");

        // Reset mid-frame after two beats popped
        drive(1'b1, 8'h71, 1'b0);
        tick();
        drive(1'b1, 8'h72, 1'b0);
        tick();
        check_beat("mr.b71", 8'h71, 1'b1);
        drive(1'b1, 8'h73, 1'b0);
        tick();
        check_beat("mr.b72", 8'h72, 1'b0);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check_idle("mr.async");
        check("mr.data", {24'd0, m_data}, 32'd0);
        check("mr.tready", {31'd0, s_axis_tready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mr.tready2", {31'd0, s_axis_tready}, 32'd1);
        check_idle("mr.flushed");
        drive(1'b1, 8'hA0, 1'b1);
        tick();
        check("mr.lat", {31'd0, m_valid}, 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check_beat("mr.bA0", 8'hA0, 1'b1);
        tick();
        check_idle("mr.end");

`ifdef ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN
        // Starvation inside a frame: three counted edges between 01 and 02
        check("uf.pre", {16'd0, m_underflow_count}, 32'd0);
        drive(1'b1, 8'h01, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check_beat("uf.b01", 8'h01, 1'b1);
        tick();
        tick();
        drive(1'b1, 8'h02, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check_beat("uf.b02", 8'h02, 1'b0);
        tick();
        tick();
        check("uf.cnt", {16'd0, m_underflow_count}, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elixirchip_es1_spu_op_source.md
# elixirchip_es1_spu_op_source

Stream-to-SPU operand source: accepts a ready/valid AXI4-Stream of operand words, buffers them in a small synchronous FIFO, and drives the `data`/`clear`/`valid` triple consumed by the ES1 SPU op chain (`s_data0`/`s_clear`/`s_valid` of `elixirchip_es1_spu_op_*`). It marks the first beat of every frame with `clear`, so accumulating ops restart per frame. It sits at the ingress of an SPU pipeline, between a DMA/stream fabric and the first op.

## Interface
- `DATA_BITS`, 8, operand width
- `data_t`, `logic [DATA_BITS-1:0]`, operand type (optional override)
- `FIFO_PTR_BITS`, 2, FIFO depth = 2**FIFO_PTR_BITS; legal range 1..8
- `CLEAR_DATA`, `'x`, `m_data` reset value
- `DEVICE`, "RTL", device name
- `SIMULATION`, "false", simulation flag
- `DEBUG`, "false", debug flag

Ports:
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `cke`  in  1  SPU clock enable; gates the output side only
- `enable`  in  1  output pop enable
- `s_axis_tdata`  in  $bits(data_t)  operand word
- `s_axis_tlast`  in  1  last beat of frame
- `s_axis_tvalid`  in  1  beat valid
- `s_axis_tready`  out  1  beat accepted when tvalid & tready
- `m_data`  out  $bits(data_t)  operand to SPU op
- `m_clear`  out  1  first beat of frame
- `m_valid`  out  1  `m_data` valid
- `m_underflow_count`  out  16  starved-cycle counter; present only with macro

## Operation
- Push: on any edge with `s_axis_tvalid & s_axis_tready`, write {tdata, tlast}. `cke` is ignored on the input side.
- `s_axis_tready` = !full, from the registered count. No push-through when full, even if a pop occurs in the same cycle.
- Pop: on an edge with `cke & enable & !empty`:
  - register `m_data` = entry data, `m_valid` = 1, `m_clear` = `sof`;
  - `sof` <= entry.last.
- Edge with `cke & !(enable & !empty)`: `m_valid` <= 0, `m_clear` <= 0, `m_data` holds.
- Edge with `cke` = 0: all output registers and `sof` hold; pushes continue.
- `sof` resets to 1, so the first beat after reset is flagged `m_clear`.
- A single-beat frame (tlast on every beat) gives `m_clear` = 1 on every beat.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo depth. Count is FIFO_PTR_BITS+1 wide.
- Deasserting `enable` mid-frame pauses output without losing `sof` state. Resume continues the frame with `m_clear` = 0.

## Timing
- Reset values (asserted immediately, asynchronously):
  - FIFO empty, pointers 0;
  - `s_axis_tready` = 0 while reset is high, 1 from the first cycle after release;
  - `m_valid` = 0, `m_clear` = 0, `m_data` = CLEAR_DATA, `sof` = 1, `m_underflow_count` = 0.
- Latency:
  - beat accepted at edge k is poppable at edge k+1 at the earliest;
  - `m_valid` is high in the cycle after edge k+1.
- Throughput: one beat per `cke` cycle at steady state. Depth 2**FIFO_PTR_BITS gives full rate with no bubbles when the source is always valid.
- Reset mid-frame: buffered beats are discarded, and the next popped beat has `m_clear` = 1.

## Configuration
- Macro: `ELIXIRCHIP_ES1_SPU_OP_SOURCE_UNDERFLOW_CNT_EN`.
- Defined:
  - `m_underflow_count` exists;
  - it increments on every edge with `cke & enable & empty & !sof`, i.e. starvation inside a frame;
  - it saturates at 16'hFFFF and clears only on reset.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `elixirchip_es1_spu_pkg` holds `UNDERFLOW_CNT_BITS = 16`.
- FIFO entry struct {data_t data; logic last;} is declared locally, since it is parameter-dependent.
- One sub-module: `elixirchip_es1_spu_fifo_sync`. It is a register-based synchronous FIFO with async reset, parameters `DATA_BITS`/`PTR_BITS`, ports wr_en/wr_data/rd_en/rd_data/full/empty/count.

## Test plan
- Reset release, tvalid=0 for 10 cycles, `cke` = `enable` = 1 -> `m_valid` = 0, tready = 1, underflow count = 0 (`sof` = 1 suppresses counting).
- Frame 0x11,0x22,0x33 (tlast on 0x33) then frame 0x44 (tlast), continuous -> outputs 0x11/clr=1, 0x22/clr=0, 0x33/clr=0, 0x44/clr=1; first `m_valid` 2 edges after first accept.
- FIFO_PTR_BITS=2, `enable` = 0, push 6 beats -> tready drops after 4 accepts; `enable` = 1 -> 4 beats out in order, then the remaining 2 with no loss.
- Toggle `cke` 1,0,1,0 during a 4-beat stream -> each output value is held across `cke` = 0 cycles; no beat is duplicated or dropped; pushes continue while `cke` = 0.
- Assert reset after 2 of 5 beats popped, then send new frame 0xA0 -> FIFO flushed, `m_valid` = 0 immediately, 0xA0 appears with `m_clear` = 1.
- With macro: frame 0x01,(3 idle cycles),0x02 tlast -> `m_underflow_count` = 3; without macro the design compiles with the port absent.
